// File: rtl/note_seq_ctrl.sv
// Note-duration sequencer: beat-tick counting, note index and playback control.
// Optional articulation gap on mute enabled by defining NOTE_GAP_EN.
module note_seq_ctrl #(
  parameter int DUR_W    = 6,
  parameter int IDX_W    = 5,
  parameter int SONG_LEN = 32,
  parameter int GAP_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk,
  input  logic [DUR_W-1:0] dur,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop,
  output logic [IDX_W-1:0] note_idx,
  output logic [DUR_W-1:0] beat_cnt,
  output logic             note_adv,
  output logic             playing,
  output logic             done,
  output logic             mute
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SONG_LEN - 1);

  state_t r_state;
  state_t w_next;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [IDX_W-1:0] r_idx;
  logic [DUR_W-1:0] r_cnt;
  logic [DUR_W-1:0] r_dur_q;
  logic             r_load;
  logic             r_adv;

  logic             w_tick;
  logic [DUR_W-1:0] w_dsrc;
  logic [DUR_W-1:0] w_deff;
  logic             w_beat_end;
  logic             w_last_note;
  logic             w_run;
  logic             w_adv;
  logic             w_step;

  // Live dur is only trusted on the load cycle; afterwards the latched copy.
  assign w_tick      = r_s2 & ~r_s3;
  assign w_dsrc      = r_load ? dur : r_dur_q;
  assign w_deff      = (w_dsrc == '0) ? DUR_W'(1) : w_dsrc;
  assign w_beat_end  = (r_cnt == w_deff - DUR_W'(1));
  assign w_last_note = (r_idx == LAST);
  assign w_run       = (r_state == S_PLAY) & ~stop & ~start & ~pause;
  assign w_adv       = w_run & w_tick & w_beat_end;
  assign w_step      = w_run & w_tick & ~w_beat_end;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = S_IDLE;
    end else if (start) begin
      w_next = S_PLAY;
    end else begin
      unique case (r_state)
        S_PLAY: begin
          if (pause)
            w_next = S_PAUSE;
          else if (w_adv && w_last_note && !loop)
            w_next = S_DONE;
        end
        S_PAUSE: begin
          if (!pause) w_next = S_PLAY;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    playing = 1'b0;
    done    = 1'b0;
    unique case (1'b1)
      (r_state == S_PLAY),
      (r_state == S_PAUSE): playing = 1'b1;
      (r_state == S_DONE):  done    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dur_q <= '0;
      r_load  <= 1'b0;
      r_adv   <= 1'b0;
    end else begin
      r_s1   <= bclk;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      if (r_load) r_dur_q <= dur;
      r_adv  <= w_adv;
      r_load <= (~stop & start) | w_adv;
      if (stop | start) begin
        r_idx <= '0;
        r_cnt <= '0;
      end else if (w_adv) begin
        r_cnt <= '0;
        if (!w_last_note)
          r_idx <= r_idx + IDX_W'(1);
        else if (loop)
          r_idx <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + DUR_W'(1);
      end
    end
  end

  assign note_idx = r_idx;
  assign beat_cnt = r_cnt;
  assign note_adv = r_adv;

`ifdef NOTE_GAP_EN
  localparam int GW = $clog2(GAP_CYC + 1);

  logic [GW-1:0] r_gap;
  logic          w_pause_in;

  assign w_pause_in = (r_state == S_PLAY) & ~stop & ~start & pause;

  // Each advance restarts the full gap; the pulse cycle itself is muted.
  always_ff @(posedge clk) begin
    if (!reset || stop || w_pause_in)
      r_gap <= '0;
    else if (w_adv)
      r_gap <= GW'(GAP_CYC);
    else if (r_gap != '0)
      r_gap <= r_gap - GW'(1);
  end

  assign mute = (r_gap != '0);
`else
  assign mute = 1'b0;
`endif

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl: vector table, directed corner cases and
// randomized playback against a cycle-level reference model.
module tb_note_seq_ctrl;

  localparam int DUR_W = 6;
  localparam int IDX_W = 5;
  localparam int LEN   = 32;
  localparam int GAP   = 4;
`ifdef NOTE_GAP_EN
  localparam logic GAP_ON = 1'b1;
`else
  localparam logic GAP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             bclk;
  logic [DUR_W-1:0] dur;
  logic             start;
  logic             stop;
  logic             pause;
  logic             loop;
  logic [IDX_W-1:0] note_idx;
  logic [DUR_W-1:0] beat_cnt;
  logic             note_adv;
  logic             playing;
  logic             done;
  logic             mute;

  note_seq_ctrl #(
    .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_LEN(LEN), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .dur(dur),
    .start(start), .stop(stop), .pause(pause), .loop(loop),
    .note_idx(note_idx), .beat_cnt(beat_cnt), .note_adv(note_adv),
    .playing(playing), .done(done), .mute(mute)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_adv = 0;

  // song table feeding dur, addressed by the expected note index
  logic [DUR_W-1:0] tab [LEN];
  logic             use_tab;

  // reference model: 0 idle, 1 play, 2 pause, 3 done
  int   m_mode, m_idx, m_cnt, m_gap;
  logic m_adv, m_load;
  logic [DUR_W-1:0] m_durq;
  logic b1, b2, b3;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic tick, adv, ld;
    logic [DUR_W-1:0] src;
    int deff;
    if (!reset) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_gap = 0;
      m_adv = 0; m_load = 0; m_durq = '0;
      b1 = 0; b2 = 0; b3 = 0;
      return;
    end
    // a rise seen by the input sampler is counted two edges later
    tick = b2 & ~b3;
    b3 = b2; b2 = b1; b1 = bclk;
    src = m_load ? dur : m_durq;
    if (m_load) m_durq = dur;
    deff = (src == 0) ? 1 : int'(src);
    adv = 0; ld = 0;
    if (stop) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_gap = 0;
    end else if (start) begin
      m_mode = 1; m_idx = 0; m_cnt = 0; ld = 1;
    end else if (m_mode == 1 && pause) begin
      m_mode = 2; m_gap = 0;
    end else if (m_mode == 2 && !pause) begin
      m_mode = 1;
    end else if (m_mode == 1 && tick) begin
      if (m_cnt + 1 == deff) begin
        adv = 1; ld = 1; m_cnt = 0;
        if (m_idx == LEN - 1) begin
          if (loop) m_idx = 0;
          else m_mode = 3;
        end else m_idx++;
      end else m_cnt++;
    end
    if (adv) m_gap = GAP;
    else if (m_gap > 0) m_gap--;
    m_adv = adv;
    m_load = ld;
  endtask

  task automatic cyc();
    logic [31:0] exp;
    if (use_tab) dur = tab[m_idx];
    model_edge();
    @(posedge clk);
    #1;
    if (note_adv) n_adv++;
    exp = {17'd0, IDX_W'(m_idx), DUR_W'(m_cnt), m_adv,
           (m_mode == 1 || m_mode == 2), (m_mode == 3),
           (GAP_ON && m_gap != 0)};
    chk("model", {17'd0, note_idx, beat_cnt, note_adv, playing, done, mute},
        exp);
  endtask

  task automatic beat();
    bclk = 1'b1;
    repeat (3) cyc();
    bclk = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 0; stop = 0; pause = 0; bclk = 0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  typedef struct {
    logic       b;
    logic       st;
    logic [5:0] d;
    int         ei;
    int         ec;
    logic       ea;
    logic       ep;
    logic       ed;
  } vec_t;

  vec_t vt [18];

  initial begin
    int hold;
    vt[0]  = '{1'b0, 1'b1, 6'd3, 0, 0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 6'd3, 0, 0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 6'd3, 0, 0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 6'd3, 0, 1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 6'd3, 0, 1, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 6'd3, 0, 1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 6'd3, 0, 1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 6'd3, 0, 1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 6'd3, 0, 1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 6'd3, 0, 2, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 6'd3, 0, 2, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 6'd3, 0, 2, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 6'd3, 0, 2, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b0, 6'd3, 0, 2, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b0, 6'd3, 0, 2, 1'b0, 1'b1, 1'b0};
    vt[15] = '{1'b1, 1'b0, 6'd3, 1, 0, 1'b1, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 6'd3, 1, 0, 1'b0, 1'b1, 1'b0};
    vt[17] = '{1'b0, 1'b0, 6'd3, 1, 0, 1'b0, 1'b1, 1'b0};

    use_tab = 1'b0; dur = '0; loop = 1'b0;
    do_reset();
    chk("reset_state", {note_idx, beat_cnt, note_adv, playing, done, mute},
        '0);

    // basic note with dur=3: beat_cnt 0,1,2,0 and one advance pulse
    for (int i = 0; i < 18; i++) begin
      bclk = vt[i].b; start = vt[i].st; dur = vt[i].d;
      cyc();
      chk($sformatf("vec%0d", i), {note_idx, beat_cnt, note_adv, playing, done},
          {IDX_W'(vt[i].ei), DUR_W'(vt[i].ec), vt[i].ea, vt[i].ep, vt[i].ed});
    end
    start = 1'b0;

    // reset mid-note at idx 5, beat 2
    do_reset();
    use_tab = 1'b1;
    for (int i = 0; i < LEN; i++) tab[i] = 6'd3;
    go();
    repeat (17) beat();
    chk("mid_idx", note_idx, 5);
    chk("mid_cnt", beat_cnt, 2);
    reset = 1'b0;
    cyc();
    chk("mid_reset", {note_idx, beat_cnt, note_adv, playing, done}, '0);
    reset = 1'b1;

    // dur=0 on note 4 behaves as one beat
    do_reset();
    for (int i = 0; i < LEN; i++) tab[i] = 6'd1;
    tab[4] = 6'd0; tab[5] = 6'd2;
    go();
    repeat (4) beat();
    chk("dur0_at4", note_idx, 4);
    beat();
    chk("dur0_idx", {note_idx, beat_cnt}, {IDX_W'(5), DUR_W'(0)});

    // end of song without loop, then with loop
    do_reset();
    for (int i = 0; i < LEN; i++) tab[i] = 6'd1;
    loop = 1'b0;
    go();
    n_adv = 0;
    repeat (LEN) beat();
    chk("end_done", {note_idx, done, playing}, {IDX_W'(LEN - 1), 1'b1, 1'b0});
    chk("end_advs", n_adv, LEN);
    repeat (3) beat();
    chk("end_hold", {note_idx, done}, {IDX_W'(LEN - 1), 1'b1});
    chk("end_noadv", n_adv, LEN);
    stop = 1'b1; cyc(); stop = 1'b0;
    loop = 1'b1;
    go();
    n_adv = 0;
    repeat (LEN) beat();
    chk("loop_wrap", {note_idx, playing, done}, {IDX_W'(0), 1'b1, 1'b0});
    chk("loop_advs", n_adv, LEN);

    // pause holds beat_cnt; remaining beats counted after resume
    do_reset();
    use_tab = 1'b0; dur = 6'd4; loop = 1'b0;
    go();
    n_adv = 0;
    beat();
    chk("pause_pre", beat_cnt, 1);
    pause = 1'b1;
    repeat (5) beat();
    chk("pause_hold", {note_idx, beat_cnt, playing}, {IDX_W'(0), DUR_W'(1), 1'b1});
    chk("pause_noadv", n_adv, 0);
    pause = 1'b0;
    cyc();
    repeat (2) beat();
    chk("resume_2", beat_cnt, 3);
    chk("resume_noadv", n_adv, 0);
    beat();
    chk("resume_adv", n_adv, 1);
    chk("resume_idx", {note_idx, beat_cnt}, {IDX_W'(1), DUR_W'(0)});

    // mute around an advance, cleared by stop
    do_reset();
    dur = 6'd1;
    go();
    bclk = 1'b1;
    repeat (3) cyc();
    chk("mute_adv", {note_adv, mute}, {1'b1, GAP_ON});
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("mute_stop", mute, 0);
    bclk = 1'b0;

    // randomized playback
    do_reset();
    for (int i = 0; i < LEN; i++) tab[i] = DUR_W'($urandom_range(0, 3));
    hold = 3;
    for (int n = 0; n < 5000; n++) begin
      if (--hold == 0) begin
        bclk = ~bclk;
        hold = $urandom_range(3, 6);
      end
      start = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 199) < 1);
      if ($urandom_range(0, 99) < 3) pause = ~pause;
      if ($urandom_range(0, 99) < 2) loop = ~loop;
      reset = ($urandom_range(0, 999) != 0);
      dur = ($urandom_range(0, 9) == 0) ? DUR_W'($urandom_range(0, 5))
                                        : tab[m_idx];
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
